// File: rtl/lab_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// lab_pkg
//   Shared measurement-block definitions: FSM state encoding and gate-window
//   length derivation.
//   Rev 1.0 - initial release
// ---------------------------------------------------------------------------
package lab_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_COUNT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    // Gate window length in system clock cycles.
    function automatic int unsigned gate_cycles(input int unsigned freq_in,
                                                input int unsigned gate_ms);
        return (freq_in / 1000) * gate_ms;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_edge_detect.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sync_edge_detect
//   Multi-flop synchronizer for an asynchronous input followed by a one-cycle
//   rising-edge pulse generator.
//   Rev 1.0 - initial release
// ---------------------------------------------------------------------------
module sync_edge_detect #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_sig,
    output logic o_rise
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_sig};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_rise = r_sync[SYNC_STAGES-1] & ~r_prev;

endmodule
`default_nettype wire

// File: rtl/freq_meter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// freq_meter
//   Gated frequency counter: counts rising edges of SIG_IN over a fixed
//   window of system clock cycles and reports the saturated count.
//   Rev 1.0 - initial release
// ---------------------------------------------------------------------------
module freq_meter
    import lab_pkg::*;
#(
    parameter int unsigned FREQ_IN     = 50000000,
    parameter int unsigned GATE_MS     = 1000,
    parameter int          WIDTH       = 32,
    parameter int          SYNC_STAGES = 2
) (
    input  logic             CLK_IN,
    input  logic             RST,
    input  logic             SIG_IN,
    input  logic             START,
    input  logic             CONTINUOUS,
    output logic [WIDTH-1:0] COUNT_OUT,
    output logic             VALID,
    output logic             OVF,
    output logic             BUSY
);

    localparam int unsigned      c_GATE_CYCLES = gate_cycles(FREQ_IN, GATE_MS);
    localparam int               c_GATE_W      = $clog2(c_GATE_CYCLES);
    localparam logic [WIDTH-1:0] c_CNT_MAX     = {WIDTH{1'b1}};
    localparam logic [c_GATE_W-1:0] c_GATE_LAST = c_GATE_W'(c_GATE_CYCLES - 1);

    logic [1:0]          r_state;
    logic [1:0]          w_state_next;
    logic [c_GATE_W-1:0] r_gate_cnt;
    logic [WIDTH-1:0]    r_edge_cnt;
    logic [WIDTH-1:0]    w_edge_cnt_next;
    logic                r_ovf;
    logic                w_ovf_next;
    logic [WIDTH-1:0]    r_count_out;
    logic                r_ovf_out;
    logic                r_valid;
    logic                w_rise;
    logic                w_counting;
    logic                w_last;
    logic                w_busy;

    sync_edge_detect #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_edge_detect (
        .clk    (CLK_IN),
        .rst    (RST),
        .i_sig  (SIG_IN),
        .o_rise (w_rise)
    );

    always_ff @(posedge CLK_IN) begin
        if (RST) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (START || CONTINUOUS) w_state_next = ST_COUNT;
            ST_COUNT: if (w_last)              w_state_next = ST_DONE;
            ST_DONE:  w_state_next = CONTINUOUS ? ST_COUNT : ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_counting = (r_state == ST_COUNT);
        w_last     = w_counting && (r_gate_cnt == c_GATE_LAST);
        w_busy     = (r_state == ST_COUNT) || (r_state == ST_DONE);
    end

    // Saturating edge count; an edge arriving at full scale marks overflow.
    always_comb begin
        w_edge_cnt_next = r_edge_cnt;
        w_ovf_next      = r_ovf;
        if (w_counting && w_rise) begin
            if (r_edge_cnt == c_CNT_MAX) begin
                w_ovf_next = 1'b1;
            end else begin
                w_edge_cnt_next = r_edge_cnt + 1'b1;
            end
        end
    end

    // Counters are held clear outside COUNT so every window starts from zero.
    // Results are loaded on the final COUNT cycle so that COUNT_OUT, OVF and
    // VALID all become visible during DONE.
    always_ff @(posedge CLK_IN) begin
        if (RST) begin
            r_gate_cnt  <= '0;
            r_edge_cnt  <= '0;
            r_ovf       <= 1'b0;
            r_count_out <= '0;
            r_ovf_out   <= 1'b0;
            r_valid     <= 1'b0;
        end else begin
            r_valid <= w_last;
            if (w_counting) begin
                r_gate_cnt <= r_gate_cnt + 1'b1;
                r_edge_cnt <= w_edge_cnt_next;
                r_ovf      <= w_ovf_next;
            end else begin
                r_gate_cnt <= '0;
                r_edge_cnt <= '0;
                r_ovf      <= 1'b0;
            end
            if (w_last) begin
                r_count_out <= w_edge_cnt_next;
                r_ovf_out   <= w_ovf_next;
            end
        end
    end

    assign COUNT_OUT = r_count_out;
    assign VALID     = r_valid;
    assign OVF       = r_ovf_out;
    assign BUSY      = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_freq_meter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_freq_meter
//   Self-checking bench for freq_meter: two instances (10-cycle/32-bit and
//   20-cycle/3-bit windows) checked against an edge-counting reference model.
//   Rev 1.0 - initial release
// ---------------------------------------------------------------------------
module tb_freq_meter;

    localparam int G_A = 10;
    localparam int G_B = 20;

    logic        clk;
    logic        rst;
    logic        sig_a, start_a, cont_a;
    logic [31:0] cnt_a;
    logic        valid_a, ovf_a, busy_a;
    logic        sig_b, start_b, cont_b;
    logic [2:0]  cnt_b;
    logic        valid_b, ovf_b, busy_b;

    int n_run  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int mode_a = 0;   // 0 hold, 1 random, 2 toggle
    bit tog_b  = 0;
    bit smp_a [0:8191];
    bit smp_b [0:8191];

    freq_meter #(
        .FREQ_IN(1000), .GATE_MS(10), .WIDTH(32), .SYNC_STAGES(2)
    ) dut_a (
        .CLK_IN(clk), .RST(rst), .SIG_IN(sig_a), .START(start_a),
        .CONTINUOUS(cont_a), .COUNT_OUT(cnt_a), .VALID(valid_a),
        .OVF(ovf_a), .BUSY(busy_a)
    );

    freq_meter #(
        .FREQ_IN(1000), .GATE_MS(20), .WIDTH(3), .SYNC_STAGES(2)
    ) dut_b (
        .CLK_IN(clk), .RST(rst), .SIG_IN(sig_b), .START(start_b),
        .CONTINUOUS(cont_b), .COUNT_OUT(cnt_b), .VALID(valid_b),
        .OVF(ovf_b), .BUSY(busy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record what each synchronizer's first flop captures at every edge.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        smp_a[cyc+1] <= rst ? 1'b0 : sig_a;
        smp_b[cyc+1] <= rst ? 1'b0 : sig_b;
    end

    // A rise seen in the interval after edge p comes from samples p-2 (low)
    // and p-1 (high); a window started at edge t counts p in [t, t+G-1].
    function automatic int edges(input bit b, input int lo, input int hi);
        int n = 0;
        for (int p = lo; p <= hi; p++) begin
            if (b ? (smp_b[p-1] && !smp_b[p-2]) : (smp_a[p-1] && !smp_a[p-2]))
                n++;
        end
        return n;
    endfunction

    function automatic logic [31:0] exp_cnt(input bit b, input int n);
        longint mx = b ? 7 : 64'hFFFF_FFFF;
        return (longint'(n) > mx) ? 32'(mx) : 32'(n);
    endfunction

    function automatic logic [31:0] exp_ovf(input bit b, input int n);
        longint mx = b ? 7 : 64'hFFFF_FFFF;
        return (longint'(n) > mx) ? 32'd1 : 32'd0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        case (mode_a)
            1:       sig_a = 1'($urandom_range(0, 1));
            2:       sig_a = ~sig_a;
            default: ;
        endcase
        if (tog_b) sig_b = ~sig_b;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One single-shot window; optionally pokes START while counting.
    task automatic run_single(input bit b, input bit poke, input string tag);
        int t, g, early, n;
        g = b ? G_B : G_A;
        if (b) start_b = 1'b1; else start_a = 1'b1;
        tick();
        t = cyc;
        start_a = 1'b0;
        start_b = 1'b0;
        chk({tag, "_busy_start"}, b ? 32'(busy_b) : 32'(busy_a), 32'd1);
        early = 0;
        for (int k = 1; k < g; k++) begin
            if (poke && k == 3) start_a = 1'b1;
            tick();
            start_a = 1'b0;
            if (b ? valid_b : valid_a) early++;
        end
        tick();
        n = edges(b, t, t + g - 1);
        chk({tag, "_early_valid"}, 32'(early), 32'd0);
        chk({tag, "_valid"}, b ? 32'(valid_b) : 32'(valid_a), 32'd1);
        chk({tag, "_count"}, b ? 32'(cnt_b) : cnt_a, exp_cnt(b, n));
        chk({tag, "_ovf"}, b ? 32'(ovf_b) : 32'(ovf_a), exp_ovf(b, n));
        tick();
        chk({tag, "_valid_drop"}, b ? 32'(valid_b) : 32'(valid_a), 32'd0);
        chk({tag, "_busy_end"}, b ? 32'(busy_b) : 32'(busy_a), 32'd0);
        early = 0;
        for (int k = 0; k < g + 2; k++) begin
            tick();
            if ((b ? valid_b : valid_a) || (b ? busy_b : busy_a)) early++;
        end
        chk({tag, "_stays_idle"}, 32'(early), 32'd0);
    endtask

    initial begin
        int t, rel, bad, n;
        rst = 1'b1;
        sig_a = 1'b0; start_a = 1'b0; cont_a = 1'b0;
        sig_b = 1'b0; start_b = 1'b0; cont_b = 1'b0;
        mode_a = 1;
        tog_b  = 1'b1;
        repeat (3) tick();
        chk("rst_cnt_a",   cnt_a,          32'd0);
        chk("rst_valid_a", 32'(valid_a),   32'd0);
        chk("rst_ovf_a",   32'(ovf_a),     32'd0);
        chk("rst_busy_a",  32'(busy_a),    32'd0);
        chk("rst_cnt_b",   32'(cnt_b),     32'd0);
        chk("rst_busy_b",  32'(busy_b),    32'd0);
        rst   = 1'b0;
        tog_b = 1'b0;
        sig_b = 1'b0;
        repeat (3) tick();

        run_single(1'b0, 1'b0, "single_rand");
        mode_a = 2;
        run_single(1'b0, 1'b0, "single_toggle");
        mode_a = 0;
        sig_a  = 1'b0;
        tick();
        sig_a  = 1'b1;
        run_single(1'b0, 1'b0, "single_high");
        mode_a = 1;
        run_single(1'b0, 1'b1, "ignored_start");

        tog_b = 1'b1;
        run_single(1'b1, 1'b0, "ovf_sat");
        tog_b = 1'b0;
        sig_b = 1'b0;
        repeat (3) tick();
        run_single(1'b1, 1'b0, "ovf_clear");

        // Continuous: three full windows, then drop CONTINUOUS mid-window.
        cont_a = 1'b1;
        tick();
        t   = cyc;
        bad = 0;
        for (int c = 1; c <= 4 * G_A + 3; c++) begin
            if (c == 3 * (G_A + 1) + 4) cont_a = 1'b0;
            tick();
            rel = cyc - t;
            if (rel % (G_A + 1) == G_A) begin
                n = edges(1'b0, cyc - G_A, cyc - 1);
                chk("cont_valid", 32'(valid_a), 32'd1);
                chk("cont_count", cnt_a, exp_cnt(1'b0, n));
                chk("cont_ovf",   32'(ovf_a), 32'd0);
            end else if (valid_a || !busy_a) begin
                bad++;
            end
        end
        chk("cont_between", 32'(bad), 32'd0);
        tick();
        chk("cont_stop_busy",  32'(busy_a),  32'd0);
        chk("cont_stop_valid", 32'(valid_a), 32'd0);
        bad = 0;
        for (int k = 0; k < G_A + 3; k++) begin
            tick();
            if (valid_a || busy_a) bad++;
        end
        chk("cont_stop_idle", 32'(bad), 32'd0);

        // Reset partway through a window aborts it without a result.
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        repeat (5) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_busy",  32'(busy_a),  32'd0);
        chk("abort_valid", 32'(valid_a), 32'd0);
        chk("abort_cnt",   cnt_a,        32'd0);
        bad = 0;
        for (int k = 0; k < G_A + 4; k++) begin
            tick();
            if (valid_a || busy_a) bad++;
        end
        chk("abort_no_valid", 32'(bad), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
